// File: rtl/alu_result_stage.sv
// Capture stage behind alu_top: show-ahead result FIFO with valid/ready, carry feedback
// for multi-word arithmetic, sticky overflow / illegal-mode status and an op counter.
module alu_result_stage #(
   parameter int ALU_WIDTH = 4,
   parameter int DEPTH     = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [5:0]                 mode_i,
   input  logic [ALU_WIDTH-1:0]       DO_i,
   input  logic                       C_i,
   input  logic                       V_i,
   input  logic                       N_i,
   input  logic                       Z_i,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [ALU_WIDTH-1:0]       out_data,
   output logic [3:0]                 out_flags,
   output logic                       carry_chain,
   output logic                       sticky_v,
   output logic                       illegal,
   input  logic                       sticky_clr,
   output logic [$clog2(DEPTH):0]     level,
   output logic [7:0]                 op_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = ALU_WIDTH + 4;
   localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   localparam logic [5:0] MODE_ADD = 6'b1001_0_1;
   localparam logic [5:0] MODE_SUB = 6'b0110_1_1;

   typedef logic [EW-1:0] entry_t;

   entry_t          mem [DEPTH];
   entry_t          last_q;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;

   logic mode_logic;
   logic mode_arith;
   logic mode_legal;
   logic push;
   logic store;
   logic pop;

   // Logic modes are {S,Cin=1,M=0}; arithmetic is limited to the two chained codes.
   assign mode_logic = (mode_i[1:0] == 2'b10);
   assign mode_arith = (mode_i == MODE_ADD) || (mode_i == MODE_SUB);
   assign mode_legal = mode_logic || mode_arith;

   assign in_ready  = (level != LVL_FULL);
   assign out_valid = (level != '0);

   assign push  = in_valid && in_ready;
   assign store = push && mode_legal;
   assign pop   = out_valid && out_ready;

   // Empty FIFO shows the last popped entry so the outputs do not wander.
   assign {out_data, out_flags} = out_valid ? mem[rd_ptr] : last_q;

   always_ff @(posedge clk) begin
      if (store) begin
         mem[wr_ptr] <= {DO_i, C_i, V_i, N_i, Z_i};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         last_q <= '0;
      end else begin
         if (store) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
            last_q <= mem[rd_ptr];
         end
         case ({store, pop})
            2'b10:   level <= level + LVL_ONE;
            2'b01:   level <= level - LVL_ONE;
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         carry_chain <= 1'b0;
         sticky_v    <= 1'b0;
         illegal     <= 1'b0;
         op_count    <= '0;
      end else begin
         if (store) begin
            op_count <= op_count + 8'd1;
         end
         if (store && mode_arith) begin
            carry_chain <= C_i;
         end
         // Set has priority over a same-cycle clear.
         if (store && mode_arith && V_i) begin
            sticky_v <= 1'b1;
         end else if (sticky_clr) begin
            sticky_v <= 1'b0;
         end
         if (push && !mode_legal) begin
            illegal <= 1'b1;
         end else if (sticky_clr) begin
            illegal <= 1'b0;
         end
      end
   end

endmodule
